scan_chain_n: RTL and testbench
===============================

SCAN_CHAIN_N -- requirements
Module: scan_chain_n

Interface
REQ-001 Parameter N, default 8: chain length in bits; legal range N >= 2.
REQ-002 Parameter CNT_W, default $clog2(N+1): shift-counter width.
REQ-003 C  input  1  clock, rising-edge active.
REQ-004 global_reset_n  input  1  asynchronous active-low reset.
REQ-005 D  input  N  functional next-state data.
REQ-006 CE  input  1  functional capture enable.
REQ-007 NbarT  input  1  manual test mode: 1 = shift, 0 = normal.
REQ-008 Si  input  1  manual scan-in.
REQ-009 So  output  1  scan-out, always equal to Q[N-1].
REQ-010 Q  output  N  chain register contents.
REQ-011 start  input  1  single-cycle request to run one automatic load/capture/unload sequence.
REQ-012 pat_in  input  N  pattern to be loaded by the sequencer.
REQ-013 resp_out  output  N  chain contents unloaded by the last completed sequence.
REQ-014 busy  output  1  high while the sequencer owns the chain.
REQ-015 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-016 A shift SHALL update Q[0] <= scan bit and Q[k] <= Q[k-1] for k = 1..N-1.
REQ-017 Per-edge priority SHALL be: reset, then sequencer (busy=1), then NbarT=1 (shift Si), then CE=1 (Q <= D), then hold.
REQ-018 The FSM SHALL have states IDLE, SHIFT, CAPTURE and DONE.
REQ-019 IDLE: start=1 SHALL latch pat_in into a shadow register, clear the counter and go to SHIFT; otherwise remain in IDLE.
REQ-020 SHIFT: for exactly N cycles the chain SHALL shift shadow[N-1-cnt] in, sampling So into a response shift register (resp <= {resp[N-2:0], So}); after the Nth shift it SHALL go to CAPTURE.
REQ-021 At the end of SHIFT, Q SHALL equal the latched pat_in and the response register SHALL equal the pre-sequence Q.
REQ-022 CAPTURE: for one cycle Q <= D regardless of CE and NbarT, then go to DONE.
REQ-023 DONE: done=1 and resp_out <= response register for one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in SHIFT and CAPTURE and 0 in IDLE and DONE.
REQ-025 Latency: start sampled at edge k gives busy for N+1 cycles, with done high in the cycle following edge k+N+1.
REQ-026 start SHALL be ignored outside IDLE, including in DONE.
REQ-027 While busy, CE, NbarT and Si SHALL be ignored.
REQ-028 resp_out SHALL hold its value except in DONE.
REQ-029 Outputs SHALL be registered; there SHALL be no combinational path from any input to So, busy, done or resp_out.

Reset
REQ-030 global_reset_n=0 SHALL immediately force Q=0, So=0, resp_out=0, busy=0, done=0, counter=0, shadow=0 and state IDLE.
REQ-031 Reset during SHIFT or CAPTURE SHALL abort the sequence with no done pulse and leave resp_out=0.
REQ-032 After reset release, the first rising edge of C SHALL already obey REQ-017.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, SHIFT=1, CAPTURE=2, DONE=3) and the default N.
REQ-034 Sub-module scan_cell SHALL implement one mux-D scan flop (D/Si select, enable, async active-low clear) and be generated N times.
REQ-035 The FSM, counter, shadow register and response register SHALL live in the top level.

Verification
REQ-036 Manual shift: N=8, Q=0, NbarT=1, Si=1,0,1,1 over 4 edges -> Q=8'h0B and So=0 throughout.
REQ-037 Priority: NbarT=1, CE=1, D=8'hFF, Si=0 from Q=0 -> Q stays 0.
REQ-038 Full sequence: preload Q=8'hA5 via CE; then pat_in=8'h3C, D=8'h5A, one-cycle start -> busy for 9 cycles with Q=8'h3C at the end of SHIFT; then Q=8'h5A, a single done pulse and resp_out=8'hA5.
REQ-039 Ignore rules: start, NbarT=1 and CE=1 pulsed mid-SHIFT -> sequence timing and results identical to REQ-038; start asserted during DONE -> no new sequence.
REQ-040 Reset abort: global_reset_n=0 at SHIFT cycle 4 -> Q=0, busy=0, no done pulse, resp_out=0; a fresh start then runs normally.
REQ-041 Boundary N=2: pat_in=2'b10 from Q=2'b01 -> busy for 3 cycles, Q=2'b10 before capture, resp_out=2'b01.

Source files
------------

// File: rtl/scan_chain_n_pkg.sv
// Shared definitions for the scan chain: default chain length and the
// sequencer state encoding.
package scan_chain_n_pkg;

  localparam int unsigned N_DEFAULT = 8;

  // Sequencer states, 2-bit encoding kept stable for downstream tooling.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/scan_chain_n_cell.sv
// One mux-D scan flop.
// Ports: clk, clr_n (async active-low clear), d (functional data),
//        si (scan data), se (1 = take si), en (update enable), q.
module scan_cell (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  input  logic si,
  input  logic se,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)  q <= 1'b0;
    else if (en) q <= se ? si : d;
  end

endmodule

// File: rtl/scan_chain_n.sv
// N-bit scan chain with manual shift/capture and an automatic
// load/capture/unload sequencer.
// Ports: C (clock), global_reset_n (async active-low), D/CE (functional
//        capture), NbarT/Si (manual shift), So/Q (chain outputs),
//        start/pat_in (sequence request + pattern), resp_out/busy/done
//        (sequence result and status).
module scan_chain_n
  import scan_chain_n_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic         C,
  input  logic         global_reset_n,
  input  logic [N-1:0] D,
  input  logic         CE,
  input  logic         NbarT,
  input  logic         Si,
  output logic         So,
  output logic [N-1:0] Q,
  input  logic         start,
  input  logic [N-1:0] pat_in,
  output logic [N-1:0] resp_out,
  output logic         busy,
  output logic         done
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]     shadow, shadow_nxt;
  logic [N-1:0]     resp, resp_nxt;
  logic [N-1:0]     resp_out_nxt;
  logic             busy_nxt, done_nxt;
  logic             scan_in_c, se_c, en_c;
  logic [N-1:0]     si_vec_c;

  // Cell k shifts from cell k-1; cell 0 takes the selected scan bit.
  if (N > 2) begin : g_si_wide
    assign si_vec_c = {Q[N-2:0], scan_in_c};
  end else begin : g_si_two
    assign si_vec_c = {Q[0], scan_in_c};
  end

  for (genvar k = 0; k < N; k++) begin : g_cell
    scan_cell u_cell (
      .clk   (C),
      .clr_n (global_reset_n),
      .d     (D[k]),
      .si    (si_vec_c[k]),
      .se    (se_c),
      .en    (en_c),
      .q     (Q[k])
    );
  end

  assign So = Q[N-1];

  // State and sequencer registers.
  always_ff @(posedge C or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      resp     <= '0;
      resp_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      resp     <= resp_nxt;
      resp_out <= resp_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state and chain control; the sequencer overrides manual controls.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shadow_nxt   = shadow;
    resp_nxt     = resp;
    resp_out_nxt = resp_out;
    scan_in_c    = Si;
    se_c         = NbarT;
    en_c         = NbarT | CE;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shadow_nxt = pat_in;
          cnt_nxt    = '0;
          state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Shadow shifts left so its MSB is always shadow[N-1-cnt] of the
        // latched pattern.
        scan_in_c  = shadow[N-1];
        se_c       = 1'b1;
        en_c       = 1'b1;
        shadow_nxt = shadow << 1;
        resp_nxt   = {resp[N-2:0], So};
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N - 1)) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        se_c         = 1'b0;
        en_c         = 1'b1;
        resp_out_nxt = resp;
        state_nxt    = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_CAPTURE);
    done_nxt = (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_scan_chain_n.sv
// Self-checking bench for scan_chain_n (N=8 main instance, N=2 boundary).
module tb_scan_chain_n;

  localparam int unsigned N = 8;

  logic C = 1'b0;
  always #5 C = ~C;

  logic         rst_n;
  logic [N-1:0] d, pat, q, resp_out;
  logic         ce, nbart, si, start, so, busy, done;

  logic [1:0]   d2, pat2, q2, resp2;
  logic         ce2, nbart2, si2, start2, so2, busy2, done2;

  scan_chain_n #(.N(8)) u8 (
    .C(C), .global_reset_n(rst_n), .D(d), .CE(ce), .NbarT(nbart), .Si(si),
    .So(so), .Q(q), .start(start), .pat_in(pat), .resp_out(resp_out),
    .busy(busy), .done(done)
  );

  scan_chain_n #(.N(2)) u2 (
    .C(C), .global_reset_n(rst_n), .D(d2), .CE(ce2), .NbarT(nbart2), .Si(si2),
    .So(so2), .Q(q2), .start(start2), .pat_in(pat2), .resp_out(resp2),
    .busy(busy2), .done(done2)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  // Reference model: phase counts cycles since the sequence was accepted
  // (0 = no sequence, 1..N = shift number, N+1 = capture, N+2 = done cycle).
  logic [N-1:0] mq, mpre, mpat, mresp;
  int           phase;

  task automatic model_clear;
    mq = '0; mpre = '0; mpat = '0; mresp = '0; phase = 0;
  endtask

  task automatic model_edge;
    if (phase == 0 || phase == int'(N) + 2) begin
      if (nbart)   mq = {mq[N-2:0], si};
      else if (ce) mq = d;
      if (phase == 0 && start) begin
        mpre  = mq;
        mpat  = pat;
        phase = 1;
      end else begin
        phase = 0;
      end
    end else if (phase <= int'(N)) begin
      // After j shifts: old contents moved up j places, pattern MSBs below.
      mq    = (mpre << phase) | (mpat >> (int'(N) - phase));
      phase = phase + 1;
    end else begin
      mq    = d;
      mresp = mpre;
      phase = int'(N) + 2;
    end
  endtask

  task automatic model_check;
    chk("rnd_q", 32'(q), 32'(mq));
    chk("rnd_so", 32'(so), 32'(mq[N-1]));
    chk("rnd_busy", 32'(busy), 32'(phase >= 1 && phase <= int'(N) + 1));
    chk("rnd_done", 32'(done), 32'(phase == int'(N) + 2));
    chk("rnd_resp_out", 32'(resp_out), 32'(mresp));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any edge.
  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_so", 32'(so), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_resp_out", 32'(resp_out), 32'h0);
    @(negedge C);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Preload A5, run a sequence with pattern 3C and capture data 5A.
  task automatic run_seq(input bit disturb, input bit start_in_done);
    int busy_cnt;
    int done_seen;
    ce = 1'b1; nbart = 1'b0; d = 8'hA5;
    tick();
    chk("seq_preload", 32'(q), 32'hA5);
    ce = 1'b0; pat = 8'h3C; d = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    chk("seq_busy_rise", 32'(busy), 32'h1);
    busy_cnt  = busy ? 1 : 0;
    done_seen = 0;
    for (int i = 1; i <= int'(N); i++) begin
      if (disturb && i == 3) begin
        start = 1'b1; nbart = 1'b1; ce = 1'b1; si = 1'b1;
      end
      tick();
      start = 1'b0; nbart = 1'b0; ce = 1'b0; si = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_seen++;
    end
    chk("seq_q_after_shift", 32'(q), 32'h3C);
    tick();
    chk("seq_busy_cycles", 32'(busy_cnt), 32'(N + 1));
    chk("seq_no_early_done", 32'(done_seen), 32'h0);
    chk("seq_q_capture", 32'(q), 32'h5A);
    chk("seq_busy_low", 32'(busy), 32'h0);
    chk("seq_done", 32'(done), 32'h1);
    chk("seq_resp_out", 32'(resp_out), 32'hA5);
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("seq_done_pulse_end", 32'(done), 32'h0);
    chk("seq_idle_busy", 32'(busy), 32'h0);
    chk("seq_resp_hold", 32'(resp_out), 32'hA5);
    tick();
    chk("seq_no_restart", 32'(busy), 32'h0);
  endtask

  typedef struct packed {
    logic       ce;
    logic       nbart;
    logic       si;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int done_cnt;
    vecs[0] = '{ce:1'b1, nbart:1'b1, si:1'b0, d:8'hFF, exp_q:8'h00, exp_so:1'b0};
    vecs[1] = '{ce:1'b0, nbart:1'b1, si:1'b1, d:8'h00, exp_q:8'h01, exp_so:1'b0};
    vecs[2] = '{ce:1'b0, nbart:1'b1, si:1'b0, d:8'h00, exp_q:8'h02, exp_so:1'b0};
    vecs[3] = '{ce:1'b0, nbart:1'b1, si:1'b1, d:8'h00, exp_q:8'h05, exp_so:1'b0};
    vecs[4] = '{ce:1'b0, nbart:1'b1, si:1'b1, d:8'h00, exp_q:8'h0B, exp_so:1'b0};
    vecs[5] = '{ce:1'b0, nbart:1'b0, si:1'b1, d:8'hFF, exp_q:8'h0B, exp_so:1'b0};
    vecs[6] = '{ce:1'b1, nbart:1'b0, si:1'b0, d:8'hC3, exp_q:8'hC3, exp_so:1'b1};
    vecs[7] = '{ce:1'b0, nbart:1'b1, si:1'b0, d:8'h00, exp_q:8'h86, exp_so:1'b1};
    vecs[8] = '{ce:1'b1, nbart:1'b1, si:1'b1, d:8'h00, exp_q:8'h0D, exp_so:1'b0};
    vecs[9] = '{ce:1'b0, nbart:1'b0, si:1'b0, d:8'h77, exp_q:8'h0D, exp_so:1'b0};

    rst_n = 1'b0;
    d = '0; pat = '0; ce = 1'b0; nbart = 1'b0; si = 1'b0; start = 1'b0;
    d2 = '0; pat2 = '0; ce2 = 1'b0; nbart2 = 1'b0; si2 = 1'b0; start2 = 1'b0;
    model_clear();
    #2;
    chk("init_q", 32'(q), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_done", 32'(done), 32'h0);
    chk("init_resp_out", 32'(resp_out), 32'h0);
    @(negedge C);
    rst_n = 1'b1;

    // Manual shift / capture / hold table.
    foreach (vecs[i]) begin
      ce = vecs[i].ce; nbart = vecs[i].nbart; si = vecs[i].si; d = vecs[i].d;
      tick();
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d_so", i), 32'(so), 32'(vecs[i].exp_so));
    end
    ce = 1'b0; nbart = 1'b0; si = 1'b0;

    run_seq(1'b0, 1'b0);
    run_seq(1'b1, 1'b1);

    // Reset in the middle of SHIFT aborts without a done pulse.
    ce = 1'b1; d = 8'hA5;
    tick();
    ce = 1'b0; pat = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_busy_before", 32'(busy), 32'h1);
    do_reset();
    done_cnt = 0;
    for (int i = 0; i < int'(N) + 3; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("abort_quiet", 32'(done_cnt), 32'h0);
    chk("abort_resp_out", 32'(resp_out), 32'h0);
    run_seq(1'b0, 1'b0);

    // Randomised run against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      ce    = 1'($urandom);
      nbart = ($urandom_range(0, 2) == 0);
      si    = 1'($urandom);
      d     = 8'($urandom);
      pat   = 8'($urandom);
      start = ($urandom_range(0, 5) == 0);
      model_edge();
      tick();
      model_check();
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    ce = 1'b0; nbart = 1'b0; start = 1'b0;

    // Boundary chain length N=2.
    ce2 = 1'b1; d2 = 2'b01;
    tick();
    chk("n2_preload", 32'(q2), 32'h1);
    ce2 = 1'b0; d2 = 2'b11; pat2 = 2'b10; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    done_cnt = busy2 ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (busy2) done_cnt++;
    end
    chk("n2_q_before_capture", 32'(q2), 32'h2);
    tick();
    chk("n2_busy_cycles", 32'(done_cnt), 32'h3);
    chk("n2_busy_low", 32'(busy2), 32'h0);
    chk("n2_done", 32'(done2), 32'h1);
    chk("n2_q_capture", 32'(q2), 32'h3);
    chk("n2_resp_out", 32'(resp2), 32'h1);
    tick();
    chk("n2_done_end", 32'(done2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
